// File: rtl/water_tank_model_pkg.sv
// Shared types and constants for the water tank plant emulator.
// LEVEL_MAX_DEF lines up with the controller's 20/50/90 thresholds.
package water_tank_model_pkg;

    localparam int LVL_W         = 8;
    localparam int LEVEL_MAX_DEF = 100;

    typedef enum logic [1:0] {
        PUMP_OFF    = 2'd0,
        PUMP_SPINUP = 2'd1,
        PUMP_RUN    = 2'd2
    } pump_state_t;

    // Saturate a 10-bit signed level candidate into [0, max_lvl].
    function automatic logic [LVL_W-1:0] clamp_level(input logic signed [9:0] v,
                                                     input logic [LVL_W-1:0] max_lvl);
        if (v < 10'sd0) begin
            return '0;
        end else if (v > $signed({2'b00, max_lvl})) begin
            return max_lvl;
        end else begin
            return v[LVL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/water_tank_model_if.sv
// Pump/level bundle between the level controller (master) and the tank plant (slave).
interface water_tank_model_if;

    logic                                   pump1_ctrl;
    logic                                   pump2_ctrl;
    logic [water_tank_model_pkg::LVL_W-1:0] water_lvl;
    logic                                   lvl_valid;
    logic                                   pump1_running;
    logic                                   pump2_running;
    logic                                   overflow;
    logic                                   dry_run;

    modport master (
        output pump1_ctrl, pump2_ctrl,
        input  water_lvl, lvl_valid, pump1_running, pump2_running, overflow, dry_run
    );

    modport slave (
        input  pump1_ctrl, pump2_ctrl,
        output water_lvl, lvl_valid, pump1_running, pump2_running, overflow, dry_run
    );

endinterface

// File: rtl/water_tank_model_pump_actuator.sv
// One pump: OFF -> SPINUP -> RUN state machine advanced only on plant ticks.
module pump_actuator
    import water_tank_model_pkg::*;
#(
    parameter int SPINUP_TICKS = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic tick,
    input  logic cmd,
    output logic running
);

    localparam int CNT_W = (SPINUP_TICKS > 1) ? $clog2(SPINUP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SPINUP_TICKS > 0) ? SPINUP_TICKS - 1 : 0);

    pump_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PUMP_OFF;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                PUMP_OFF: begin
                    if (cmd) begin
                        cnt_d   = '0;
                        state_d = (SPINUP_TICKS == 0) ? PUMP_RUN : PUMP_SPINUP;
                    end
                end
                PUMP_SPINUP: begin
                    if (!cmd) begin
                        state_d = PUMP_OFF;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PUMP_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PUMP_RUN: begin
                    if (!cmd) begin
                        state_d = PUMP_OFF;
                    end
                end
                default: state_d = PUMP_OFF;
            endcase
        end
        running_d = (state_d == PUMP_RUN);
    end

    assign running = running_q;

endmodule

// File: rtl/water_tank_model.sv
// Tank plant: prescaled tick, two pump actuators, saturating level integrator and fault flags.
module water_tank_model
    import water_tank_model_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int FILL_STEP    = 1,
    parameter int DRAIN_STEP   = 1,
    parameter int LEVEL_MAX    = LEVEL_MAX_DEF,
    parameter int SPINUP_TICKS = 2
) (
    input  logic               clock,
    input  logic               rst_n,
    water_tank_model_if.slave  bus
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]        PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [LVL_W-1:0]        LVL_MAX_V = LVL_W'(LEVEL_MAX);
    localparam logic signed [9:0]       FILL_S    = 10'(FILL_STEP);
    localparam logic signed [9:0]       DRAIN_S   = 10'(DRAIN_STEP);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [LVL_W-1:0] level_q, level_d;
    logic             lvl_valid_q, lvl_valid_d;
    logic             overflow_q, overflow_d;
    logic             dry_run_q, dry_run_d;
    logic signed [9:0] level_sum;
    logic [1:0]       cmd_vec;
    logic [1:0]       run_vec;

    assign cmd_vec = {bus.pump2_ctrl, bus.pump1_ctrl};

    for (genvar gi = 0; gi < 2; gi++) begin : g_pump
        pump_actuator #(
            .SPINUP_TICKS (SPINUP_TICKS)
        ) u_pump (
            .clock   (clock),
            .rst_n   (rst_n),
            .tick    (tick),
            .cmd     (cmd_vec[gi]),
            .running (run_vec[gi])
        );
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            level_q     <= '0;
            lvl_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            dry_run_q   <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            level_q     <= level_d;
            lvl_valid_q <= lvl_valid_d;
            overflow_q  <= overflow_d;
            dry_run_q   <= dry_run_d;
        end
    end

    assign tick = (pre_q == PRE_LAST);

    // run_vec holds the pump states from before this tick's FSM step,
    // so the integrator sees the pre-transition pumps as intended.
    always_comb begin
        pre_d       = tick ? '0 : pre_q + 1'b1;
        lvl_valid_d = tick;
        level_d     = level_q;
        overflow_d  = overflow_q;
        dry_run_d   = dry_run_q;
        level_sum   = $signed({2'b00, level_q})
                    + (run_vec[0] ? FILL_S  : 10'sd0)
                    - (run_vec[1] ? DRAIN_S : 10'sd0);
        if (tick) begin
            level_d    = clamp_level(level_sum, LVL_MAX_V);
            overflow_d = run_vec[0] && (overflow_q || (level_q == LVL_MAX_V));
            dry_run_d  = run_vec[1] && (dry_run_q  || (level_q == '0));
        end
    end

    assign bus.water_lvl     = level_q;
    assign bus.lvl_valid     = lvl_valid_q;
    assign bus.pump1_running = run_vec[0];
    assign bus.pump2_running = run_vec[1];
    assign bus.overflow      = overflow_q;
    assign bus.dry_run       = dry_run_q;

endmodule

// File: doc/water_tank_model.md
# water_tank_model

Plant emulator for the water-level controller: the other end of the pump/level interface. It consumes the two pump commands (fill and drain) and produces the 8-bit `water_lvl` that the controller reads. Each pump has a spin-up delay, and the level is integrated at a prescaled plant rate with saturation and fault flags. It sits beside the controller on the FPGA demo build and in closed-loop benches, replacing the physical tank and sensor.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clocks per plant tick. Must be ≥1.
- `FILL_STEP`, default 1: level units added per tick while pump 1 is running.
- `DRAIN_STEP`, default 1: level units removed per tick while pump 2 is running.
- `LEVEL_MAX`, default 100: saturation ceiling. Must be ≤255.
- `SPINUP_TICKS`, default 2: ticks spent in SPINUP before RUN. 0 means go straight to RUN.

Ports:
- `clock`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `pump1_ctrl`, in, 1: fill command from the controller.
- `pump2_ctrl`, in, 1: drain command from the controller.
- `water_lvl`, out, 8: current level, 0..LEVEL_MAX.
- `lvl_valid`, out, 1: one-cycle pulse on each cycle in which `water_lvl` is updated.
- `pump1_running`, out, 1: pump 1 FSM is in RUN.
- `pump2_running`, out, 1: pump 2 FSM is in RUN.
- `overflow`, out, 1: fill requested while the tank is full.
- `dry_run`, out, 1: drain requested while the tank is empty.

## Operation
- Prescaler counts 0..TICK_DIV-1. Internal `tick` asserts while the count equals TICK_DIV-1, then the count wraps to 0.
- All plant state changes happen only on `tick`. Pump commands are sampled only on `tick`.
- Per-pump FSM, states OFF, SPINUP, RUN:
  - OFF with cmd=1: go to SPINUP with cnt=0, or directly to RUN if SPINUP_TICKS=0.
  - SPINUP with cmd=0: go to OFF.
  - SPINUP with cnt=SPINUP_TICKS-1: go to RUN. Otherwise cnt+1.
  - RUN with cmd=0: go to OFF.
  - There is no spin-down delay.
- Level update on `tick` uses the pump states held *before* this tick's FSM transition.
  - delta = (p1 RUN ? +FILL_STEP : 0) − (p2 RUN ? DRAIN_STEP : 0).
  - Computed in 10-bit signed arithmetic, then clamped to [0, LEVEL_MAX].
  - Both pumps running gives the net delta. With equal steps the level is unchanged.
- `overflow`: set on a tick where p1 is in RUN and the pre-update level equals LEVEL_MAX. Cleared on the first tick where p1 is not in RUN. Hold-until-clear, not sticky across pump-off.
- `dry_run`: same rule, using p2 and a level of 0.
- `lvl_valid` pulses on every tick, including ticks where the level does not change.

## Timing
- Reset values: `water_lvl`=0, `lvl_valid`=0, both FSMs OFF, `pump*_running`=0, `overflow`=0, `dry_run`=0, prescaler=0.
- Reset asserted mid-operation clears everything immediately. The first tick after release occurs TICK_DIV clocks later.
- Latency from a command being sampled on tick 1 to the first level change: tick SPINUP_TICKS+2.
- `water_lvl`, `lvl_valid`, flags and `pump*_running` are all registered. Each changes on the clock edge at which `tick` is high.
- A command pulse that falls entirely between ticks is ignored.
- A command dropped during SPINUP aborts with no level change. Re-asserting it restarts SPINUP from cnt=0.

## Structure
- The shared package holds:
  - the pump state enum (OFF/SPINUP/RUN);
  - level width (8);
  - the default LEVEL_MAX, which must match the controller's 20/50/90 thresholds for a consistent demo.
- One sub-module, `pump_actuator`:
  - ports: clock, rst_n, tick, cmd, running;
  - contains the FSM and spin-up counter;
  - instantiated twice.
- Top level holds the prescaler, level integrator, clamp and flags.

## Test plan
- Fill from reset (TICK_DIV=4, SPINUP_TICKS=2, pump1=1):
  - `pump1_running` rises on tick 3;
  - `water_lvl` reads 1 at tick 4;
  - reads 10 at tick 13;
  - `lvl_valid` pulses every 4 clocks.
- Saturation (level 99, pump1 held): 100 on the next tick and stays 100. `overflow`=1 on the following tick, then 0 on the first tick after pump1 drops.
- Drain and dry run (level 2, pump2 held, SPINUP_TICKS=0): level goes 1 then 0. `dry_run` asserts on the next tick. Level never wraps to 255.
- Both pumps (FILL_STEP=3, DRAIN_STEP=1, both in RUN, level 50): 52, 54, ...; no flags.
- Spin-up abort and reset: pump1 dropped after 1 SPINUP tick gives no level change and `running`=0. Then `rst_n` is pulsed low mid-fill at level 37: all outputs are 0 asynchronously, and `lvl_valid` next pulses TICK_DIV clocks after release.
- Closed loop with the level controller (defaults, TICK_DIV=4):
  - level rises from 0 to 90;
  - drains back below 21;
  - refills;
  - `water_lvl` stays within 0..LEVEL_MAX for 3 full cycles.
